// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the clear-engine state encoding.
package vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_TOTAL   = 525;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/vga_scan_addr_gen.sv
// Two-pixel lookahead on the sync counters: decides whether this pclk is a
// scanout read slot and which framebuffer word that read targets.
module vga_scan_addr_gen
  import vga_pkg::*;
#(
  parameter int unsigned FB_W        = 160,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned ADDR_W      = 15
) (
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  output logic              scan_slot,
  output logic [ADDR_W-1:0] scan_addr
);

  logic [9:0] h_sum;
  logic [9:0] h_la;
  logic [9:0] v_la;

  always_comb begin
    h_sum = hcount + 10'd2;
    if (h_sum >= 10'(H_TOTAL)) begin
      h_la = h_sum - 10'(H_TOTAL);
      v_la = (vcount == 10'(V_TOTAL - 1)) ? '0 : vcount + 10'd1;
    end else begin
      h_la = h_sum;
      v_la = vcount;
    end
    scan_slot = (h_la[SCALE_SHIFT-1:0] == '0) &&
                (h_la < 10'(H_VISIBLE)) &&
                (v_la < 10'(V_VISIBLE));
    // Constant multiply by FB_W; synthesis reduces it to shift-add.
    scan_addr = ADDR_W'(v_la >> SCALE_SHIFT) * ADDR_W'(FB_W) +
                ADDR_W'(h_la >> SCALE_SHIFT);
  end

endmodule

// File: rtl/vga_vram_scheduler.sv
// Single-port VRAM arbiter: scanout prefetch beats the clear engine, which
// beats the host write port. Also registers the scanout pixel.
module vga_vram_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned FB_W        = 160,
  parameter int unsigned FB_H        = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              display,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rgb,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic              scan_d1_q, scan_d1_d;
  logic              scan_slot;
  logic [ADDR_W-1:0] scan_addr;

  vga_scan_addr_gen #(
    .FB_W        (FB_W),
    .SCALE_SHIFT (SCALE_SHIFT),
    .ADDR_W      (ADDR_W)
  ) u_scan (
    .hcount    (hcount),
    .vcount    (vcount),
    .scan_slot (scan_slot),
    .scan_addr (scan_addr)
  );

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      clr_addr_q <= '0;
      color_q    <= '0;
      pix_q      <= '0;
      scan_d1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      color_q    <= color_d;
      pix_q      <= pix_d;
      scan_d1_q  <= scan_d1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    color_d    = color_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          color_d    = clr_color;
        end
      end
      ST_CLEAR: begin
        if (!scan_slot) begin
          if (clr_addr_q == LAST_ADDR) begin
            state_d    = ST_IDLE;
            clr_addr_d = '0;
          end else begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data arrives the cycle after the slot; it is captured on the edge
  // entering the first pclk of the upscaled pixel.
  always_comb begin
    scan_d1_d = scan_slot;
    pix_d     = scan_d1_q ? mem_rdata : pix_q;
  end

  always_comb begin
    wr_ready  = rst && !scan_slot && (state_q == ST_IDLE);
    clr_busy  = (state_q == ST_CLEAR);
    rgb       = display ? pix_q : '0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (scan_slot) begin
      mem_addr = scan_addr;
    end else if (state_q == ST_CLEAR) begin
      mem_addr  = clr_addr_q;
      mem_we    = 1'b1;
      mem_wdata = color_q;
    end else if (wr_valid && wr_ready) begin
      mem_addr  = wr_addr;
      mem_we    = 1'b1;
      mem_wdata = wr_data;
    end
  end

endmodule

// File: tb/tb_vga_vram_scheduler.sv
// Directed bench for vga_vram_scheduler with a scoreboard for scanout pixels
// and clear-engine writes.
module tb_vga_vram_scheduler;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned FB_PIX = 160 * 120;

  logic              pclk = 1'b0;
  logic              rst;
  logic [9:0]        hcount, vcount;
  logic              display;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rgb;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;

  vga_vram_scheduler #(
    .FB_W        (160),
    .FB_H        (120),
    .SCALE_SHIFT (2),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .hcount    (hcount),
    .vcount    (vcount),
    .display   (display),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rgb       (rgb),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0]        pix_sb[$];
  logic [ADDR_W+DATA_W-1:0] clr_sb[$];
  int hc, vc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic go(input int h, input int v);
    @(posedge pclk);
    #1;
    hcount = 10'(h);
    vcount = 10'(v);
    #1;
  endtask

  task automatic adv();
    hc++;
    if (hc == 800) begin
      hc = 0;
      vc = (vc == 524) ? 0 : vc + 1;
    end
    go(hc, vc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] pat [3];
    logic [DATA_W-1:0] cur;
    logic [ADDR_W+DATA_W-1:0] e;
    int rdy_bad, writes, hh;
    bit done, found;

    pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'h3C;
    cur = '0;
    rst = 1'b0; hcount = '0; vcount = '0; display = 1'b1; mem_rdata = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0; clr_color = '0;

    repeat (3) go(300, 10);
    go(0, 500);
    rst = 1'b1;
    #1;
    check("rel_wr_ready", wr_ready, 1);
    check("rel_busy", clr_busy, 0);
    check("rel_rgb", rgb, 0);

    // Scanout: reads at h%4==2, data at h%4==3, pixel shown h%4==0..3.
    for (int h = 2; h < 14; h++) begin
      go(h, 5);
      if (h % 4 == 2) begin
        check("scan_addr", mem_addr, 160 + (h + 2) / 4);
        check("scan_we", mem_we, 0);
      end
      if (h % 4 == 3) begin
        mem_rdata = pat[(h - 3) / 4];
        pix_sb.push_back(pat[(h - 3) / 4]);
      end else begin
        mem_rdata = 8'hFF;
      end
      if (h % 4 == 0) begin
        if (pix_sb.size() == 0) check("pix_sb_empty", 1, 0);
        else cur = pix_sb.pop_front();
      end
      if (h >= 4) check("scan_rgb", rgb, cur);
    end
    display = 1'b0;
    #1;
    check("blank_rgb", rgb, 0);
    display = 1'b1;
    #1;
    check("unblank_rgb", rgb, 8'h3C);

    // Asynchronous reset mid-line, with a host write pending.
    go(300, 5);
    wr_valid = 1'b1; wr_addr = 15'h0055; wr_data = 8'h11;
    #1;
    check("pre_rst_we", mem_we, 1);
    rst = 1'b0;
    #1;
    check("rst_rgb", rgb, 0);
    check("rst_we", mem_we, 0);
    check("rst_busy", clr_busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    wr_valid = 1'b0;
    go(301, 5);
    go(0, 500);
    rst = 1'b1;
    #1;
    check("rst_rel_wr_ready", wr_ready, 1);

    // Lookahead wraps across line and frame boundaries.
    go(798, 3);
    check("wrap_addr_v3", mem_addr, 160);
    check("wrap_we_v3", mem_we, 0);
    go(798, 524);
    check("wrap_addr_v524", mem_addr, 0);
    check("wrap_rdy_v524", wr_ready, 0);
    go(798, 478);
    check("wrap_addr_v478", mem_addr, 119 * 160);
    go(798, 479);
    check("wrap_rdy_v479", wr_ready, 1);
    check("wrap_addr_v479", mem_addr, 0);

    // Host write colliding with a scan slot.
    go(2, 0);
    wr_valid = 1'b1; wr_addr = 15'h1234; wr_data = 8'h77;
    #1;
    check("coll_rdy", wr_ready, 0);
    check("coll_we", mem_we, 0);
    check("coll_addr", mem_addr, 1);
    go(3, 0);
    check("coll_rdy2", wr_ready, 1);
    check("coll_we2", mem_we, 1);
    check("coll_waddr", mem_addr, 15'h1234);
    check("coll_wdata", mem_wdata, 8'h77);
    go(1, 500);
    wr_addr = 15'h7FFF; wr_data = 8'hC3;
    #1;
    check("oor_we", mem_we, 1);
    check("oor_addr", mem_addr, 15'h7FFF);
    wr_valid = 1'b0;

    // Full clear in vblank, host contending, second start ignored.
    hc = 0; vc = 480;
    go(hc, vc);
    display = 1'b0;
    clr_start = 1'b1; clr_color = 8'h1C;
    for (int a = 0; a < FB_PIX; a++) clr_sb.push_back({15'(a), 8'h1C});
    wr_valid = 1'b1; wr_addr = 15'h0123; wr_data = 8'h99;
    adv();
    clr_start = 1'b0;
    check("clr_busy_on", clr_busy, 1);
    check("clr_rdy_off", wr_ready, 0);
    done = 1'b0;
    rdy_bad = 0;
    for (int c = 0; c < 25000 && !done; c++) begin
      if (!clr_busy) begin
        done = 1'b1;
      end else begin
        if (wr_ready) rdy_bad++;
        if (mem_we) begin
          if (clr_sb.size() == 0) begin
            check("clr_extra_write", mem_addr, 15'h7FFF);
          end else begin
            e = clr_sb.pop_front();
            check("clr_write", {mem_addr, mem_wdata}, e);
          end
        end
        if (c == 50) begin
          clr_start = 1'b1; clr_color = 8'hE0;
        end else begin
          clr_start = 1'b0;
        end
        adv();
      end
    end
    clr_start = 1'b0;
    check("clr_done", done, 1);
    check("clr_sb_left", clr_sb.size(), 0);
    check("clr_rdy_viol", rdy_bad, 0);
    check("clr_host_resume_we", mem_we, 1);
    check("clr_host_resume_addr", mem_addr, 15'h0123);
    wr_valid = 1'b0;

    // Clear in the visible area: 3 writes per 4 pclk, then abort by reset.
    go(100, 10);
    display = 1'b1;
    clr_start = 1'b1; clr_color = 8'h4B;
    go(101, 10);
    clr_start = 1'b0;
    writes = 0;
    for (int k = 0; k < 4; k++) begin
      if (mem_we) writes++;
      go(102 + k, 10);
    end
    check("vis_clr_rate", writes, 3);
    hh = 105;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      if (mem_we && mem_addr == 15'd100) begin
        found = 1'b1;
      end else begin
        hh++;
        go(hh, 10);
      end
    end
    check("abort_reached_100", found, 1);
    check("abort_wdata", mem_wdata, 8'h4B);
    rst = 1'b0;
    #1;
    check("abort_busy", clr_busy, 0);
    check("abort_we", mem_we, 0);
    go(hh + 1, 10);
    go(0, 500);
    rst = 1'b1;
    wr_valid = 1'b1; wr_addr = 15'h0042; wr_data = 8'h24;
    #1;
    check("abort_rel_busy", clr_busy, 0);
    check("abort_rel_rdy", wr_ready, 1);
    check("abort_rel_addr", mem_addr, 15'h0042);
    go(1, 500);
    check("abort_idle_busy", clr_busy, 0);
    wr_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
